// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: data-processing opcodes and NZCV bit indices.
package ex_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational data-processing ALU: result plus NZCV for the current operation.
module alu_core
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              shifter_carry,
    input  logic [3:0]        op,
    input  logic              carry_q,
    input  logic              ovf_q,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    // Every arithmetic op is folded onto one adder: x + y + cin.
    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic              add_cin;
    logic [DATA_W:0]   add_sum;
    logic              is_arith;

    // Select adder operands and carry-in; subtraction is x + ~y + cin (C = NOT borrow).
    always_comb begin
        add_x    = a;
        add_y    = b;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        unique case (op)
            OP_SUB, OP_CMP: begin add_y = ~b; add_cin = 1'b1; end
            OP_RSB:         begin add_x = b; add_y = ~a; add_cin = 1'b1; end
            OP_ADD, OP_CMN: begin add_cin = 1'b0; end
            OP_ADC:         begin add_cin = carry_q; end
            OP_SBC:         begin add_y = ~b; add_cin = carry_q; end
            OP_RSC:         begin add_x = b; add_y = ~a; add_cin = carry_q; end
            default:        begin is_arith = 1'b0; end
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};

    // Result mux and flag generation; logical ops take C from the shifter and keep V.
    always_comb begin
        result = add_sum[DATA_W-1:0];
        unique case (op)
            OP_AND, OP_TST: result = a & b;
            OP_EOR, OP_TEQ: result = a ^ b;
            OP_ORR:         result = a | b;
            OP_MOV:         result = b;
            OP_BIC:         result = a & ~b;
            OP_MVN:         result = ~b;
            default:        result = add_sum[DATA_W-1:0];
        endcase

        flags        = 4'b0000;
        flags[FLG_N] = result[DATA_W-1];
        flags[FLG_Z] = (result == '0);
        if (is_arith) begin
            flags[FLG_C] = add_sum[DATA_W];
            flags[FLG_V] = (add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                           (add_sum[DATA_W-1] != add_x[DATA_W-1]);
        end else begin
            flags[FLG_C] = shifter_carry;
            flags[FLG_V] = ovf_q;
        end
    end

endmodule

// File: rtl/ex_alu_branch_unit.sv
// Execute stage: ALU with condition-flag register, branch target adder and branch/link decision.
module ex_alu_branch_unit
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFFS_W = 24
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic              shifter_carry,
    input  logic [3:0]        alu_op,
    input  logic              s_enable,
    input  logic [DATA_W-1:0] pc4,
    input  logic [OFFS_W-1:0] offset,
    input  logic              b_instr,
    input  logic              bl_instr,
    input  logic              cond_true,
    output logic [DATA_W-1:0] alu_out,
    output logic [3:0]        alu_flags,
    output logic [3:0]        flags_q,
    output logic [3:0]        flags_eff,
    output logic [DATA_W-1:0] target_addr,
    output logic              t_addr,
    output logic              bl_reg
);

    logic [DATA_W-1:0] offs_ext;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .a             (alu_a),
        .b             (alu_b),
        .shifter_carry (shifter_carry),
        .op            (alu_op),
        .carry_q       (flags_q[FLG_C]),
        .ovf_q         (flags_q[FLG_V]),
        .result        (alu_out),
        .flags         (alu_flags)
    );

    // NZCV register: reset has priority over an S-bit load.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            flags_q <= 4'b0000;
        end else if (s_enable) begin
            flags_q <= alu_flags;
        end
    end

    // Condition tester sees the flags this instruction is about to write.
    assign flags_eff = s_enable ? alu_flags : flags_q;

    // Word offset, sign-extended and scaled to bytes; target wraps silently.
    assign offs_ext    = {{(DATA_W - OFFS_W - 2){offset[OFFS_W-1]}}, offset, 2'b00};
    assign target_addr = pc4 + offs_ext;

    // BL arrives with b_instr also set, so it both redirects fetch and writes R14.
    assign t_addr = b_instr & cond_true;
    assign bl_reg = bl_instr & cond_true;

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// Directed self-checking bench for ex_alu_branch_unit.
module tb_ex_alu_branch_unit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        shifter_carry;
    logic [3:0]  alu_op;
    logic        s_enable;
    logic [31:0] pc4;
    logic [23:0] offset;
    logic        b_instr;
    logic        bl_instr;
    logic        cond_true;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags;
    logic [3:0]  flags_q;
    logic [3:0]  flags_eff;
    logic [31:0] target_addr;
    logic        t_addr;
    logic        bl_reg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    ex_alu_branch_unit #(
        .DATA_W (32),
        .OFFS_W (24)
    ) dut (
        .CLK           (CLK),
        .CLR           (CLR),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .shifter_carry (shifter_carry),
        .alu_op        (alu_op),
        .s_enable      (s_enable),
        .pc4           (pc4),
        .offset        (offset),
        .b_instr       (b_instr),
        .bl_instr      (bl_instr),
        .cond_true     (cond_true),
        .alu_out       (alu_out),
        .alu_flags     (alu_flags),
        .flags_q       (flags_q),
        .flags_eff     (flags_eff),
        .target_addr   (target_addr),
        .t_addr        (t_addr),
        .bl_reg        (bl_reg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so outputs are sampled away from it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        #1;
    endtask

    initial begin
        CLR = 1'b1; alu_a = '0; alu_b = '0; shifter_carry = 1'b0; alu_op = 4'h0;
        s_enable = 1'b0; pc4 = '0; offset = '0; b_instr = 1'b0; bl_instr = 1'b0;
        cond_true = 1'b0;

        // Reset
        tick();
        check("reset_flags", {28'b0, flags_q}, 32'h0);

        // Load a nonzero flag value: 0x80000000 + 0x80000000 -> 0, Z C V set
        CLR = 1'b0; s_enable = 1'b1;
        alu(4'h4, 32'h8000_0000, 32'h8000_0000);
        check("add_wrap_out", alu_out, 32'h0);
        check("add_wrap_flags", {28'b0, alu_flags}, 32'h7);
        check("eff_s1", {28'b0, flags_eff}, 32'h7);
        tick();
        check("flags_loaded", {28'b0, flags_q}, 32'h7);

        // Reset wins over s_enable
        CLR = 1'b1; s_enable = 1'b1;
        alu(4'hF, 32'h0, 32'h0);
        tick();
        check("reset_wins", {28'b0, flags_q}, 32'h0);
        CLR = 1'b0; s_enable = 1'b0;
        tick();
        check("hold_after_reset", {28'b0, flags_q}, 32'h0);
        check("eff_s0", {28'b0, flags_eff}, 32'h0);

        // ADD overflow
        s_enable = 1'b1;
        alu(4'h4, 32'h7FFF_FFFF, 32'h1);
        check("add_ovf_out", alu_out, 32'h8000_0000);
        check("add_ovf_flags", {28'b0, alu_flags}, 32'h9);
        tick();
        check("add_ovf_flags_q", {28'b0, flags_q}, 32'h9);
        s_enable = 1'b0;

        // SUB / CMP / RSB
        alu(4'hA, 32'h5, 32'h5);
        check("cmp_eq_out", alu_out, 32'h0);
        check("cmp_eq_flags", {28'b0, alu_flags}, 32'h6);
        alu(4'h2, 32'h3, 32'h5);
        check("sub_neg_out", alu_out, 32'hFFFF_FFFE);
        check("sub_neg_flags", {28'b0, alu_flags}, 32'h8);
        alu(4'h3, 32'h3, 32'h5);
        check("rsb_out", alu_out, 32'h2);
        check("rsb_flags", {28'b0, alu_flags}, 32'h2);
        tick();
        check("hold_s0", {28'b0, flags_q}, 32'h9);

        // Carry-in ops with Cq=1 (load 0110 from CMP 5,5)
        s_enable = 1'b1;
        alu(4'hA, 32'h5, 32'h5);
        tick();
        s_enable = 1'b0;
        check("cq1_loaded", {28'b0, flags_q}, 32'h6);
        alu(4'h5, 32'h1, 32'h1);
        check("adc_c1", alu_out, 32'h3);
        alu(4'h6, 32'h5, 32'h2);
        check("sbc_c1", alu_out, 32'h3);
        alu(4'h7, 32'h2, 32'h5);
        check("rsc_c1", alu_out, 32'h3);

        // Cq=0 (load 1000 from SUB 3,5)
        s_enable = 1'b1;
        alu(4'h2, 32'h3, 32'h5);
        tick();
        s_enable = 1'b0;
        alu(4'h6, 32'h5, 32'h2);
        check("sbc_c0", alu_out, 32'h2);
        alu(4'h5, 32'h1, 32'h1);
        check("adc_c0", alu_out, 32'h2);

        // Logical ops with Vq=1 (load 1001 from ADD overflow)
        s_enable = 1'b1;
        alu(4'h4, 32'h7FFF_FFFF, 32'h1);
        tick();
        s_enable = 1'b0;
        shifter_carry = 1'b1;
        alu(4'hE, 32'hFF, 32'h0F);
        check("bic_out", alu_out, 32'hF0);
        check("bic_flags", {28'b0, alu_flags}, 32'h3);
        alu(4'hF, 32'h0, 32'h0);
        check("mvn_out", alu_out, 32'hFFFF_FFFF);
        check("mvn_n", {31'b0, alu_flags[3]}, 32'h1);
        shifter_carry = 1'b0;
        alu(4'hC, 32'hF0, 32'h0F);
        check("orr_out", alu_out, 32'hFF);
        alu(4'h9, 32'hA5, 32'hA5);
        check("teq_flags", {28'b0, alu_flags}, 32'h5);
        alu(4'h0, 32'hF0F0_0000, 32'hFF00_0000);
        check("and_out", alu_out, 32'hF000_0000);
        alu(4'hD, 32'h1234, 32'h5678);
        check("mov_out", alu_out, 32'h5678);

        // Branch target and taken/link decisions
        pc4 = 32'h10; offset = 24'hFFFFFE; #1;
        check("target_back", target_addr, 32'h08);
        offset = 24'h000003; #1;
        check("target_fwd", target_addr, 32'h1C);
        pc4 = 32'h0; offset = 24'hFFFFFF; #1;
        check("target_wrap", target_addr, 32'hFFFF_FFFC);
        b_instr = 1'b1; bl_instr = 1'b1; cond_true = 1'b1; #1;
        check("bl_taken", {30'b0, t_addr, bl_reg}, 32'h3);
        cond_true = 1'b0; #1;
        check("bl_not_taken", {30'b0, t_addr, bl_reg}, 32'h0);
        bl_instr = 1'b0; cond_true = 1'b1; #1;
        check("b_taken", {30'b0, t_addr, bl_reg}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
